// File: rtl/processor_multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the datapath/memory side (slave).
// Carries the opcode and memory handshake in, plus every datapath control and status output.
interface processor_multicycle_control_if #(
  parameter int STATE_W = 4
);
  logic [5:0]         ctl_op;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               i_or_d;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_src;
  logic               instr_done;
  logic               illegal_op;
  logic [STATE_W-1:0] state_out;

  modport master (
    input  ctl_op, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, instr_done, illegal_op, state_out
  );

  modport slave (
    output ctl_op, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, instr_done, illegal_op, state_out
  );
endinterface

// File: rtl/processor_multicycle_control.sv
// Moore FSM sequencing MIPS instructions through the multicycle datapath (LW 5, SW/R/ADDI 4, BEQ/J 3 cycles).
// Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR holds the state and adds one cycle with outputs unchanged.
module processor_multicycle_control #(
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_J    = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  processor_multicycle_control_if.master       bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t     r_state;
  logic       w_op_legal;
  logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write;
  logic       w_ir_write, w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;
  logic       w_instr_done, w_illegal_op;

  always_comb begin
    w_op_legal = 1'b0;
    case (bus.ctl_op)
      OP_LW, OP_SW, OP_R, OP_BEQ: w_op_legal = 1'b1;
      OP_ADDI:                    w_op_legal = ENABLE_ADDI;
      OP_J:                       w_op_legal = ENABLE_J;
      default:                    w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (!w_op_legal) begin
            r_state <= S_FETCH;
          end else begin
            case (bus.ctl_op)
              OP_LW, OP_SW: r_state <= S_MEMADR;
              OP_R:         r_state <= S_EXECUTE;
              OP_BEQ:       r_state <= S_BRANCH;
              OP_ADDI:      r_state <= S_ADDIEX;
              OP_J:         r_state <= S_JUMP;
              default:      r_state <= S_FETCH;
            endcase
          end
        end
        S_MEMADR:  r_state <= (bus.ctl_op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (bus.mem_ready) r_state <= S_MEMWB;
        S_MEMWR:   if (bus.mem_ready) r_state <= S_FETCH;
        S_EXECUTE: r_state <= S_ALUWB;
        S_ADDIEX:  r_state <= S_ADDIWB;
        // Codes 12-15 recover here as well as every terminal state.
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_src        = 2'b00;
    w_instr_done    = 1'b0;
    w_illegal_op    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_b  = 2'b11;
        w_illegal_op = !w_op_legal;
      end
      S_MEMADR, S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_mem_write  = 1'b1;
        w_i_or_d     = 1'b1;
        w_instr_done = bus.mem_ready;
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_dst    = 1'b1;
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_src        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_instr_done    = 1'b1;
      end
      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.i_or_d        = w_i_or_d;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.ir_write      = w_ir_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.reg_write     = w_reg_write;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_src        = w_pc_src;
  assign bus.instr_done    = w_instr_done;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.state_out     = STATE_W'(r_state);

endmodule

// File: doc/processor_multicycle_control.md
# processor_multicycle_control

Multicycle successor to the single-cycle control decoder. A Moore-style state machine steps each MIPS instruction through fetch, decode, execute, memory and write-back cycles. It drives the shared-ALU, single-memory multicycle datapath, with optional ADDI and J support selected by parameter. A `mem_ready` handshake lets memory accesses stall the sequence.

## Interface
Parameters:
- `ENABLE_ADDI`, default 1: decode opcode 6'b001000 (ADDI); 0 treats it as illegal.
- `ENABLE_J`, default 1: decode opcode 6'b000010 (J); 0 treats it as illegal.
- `STATE_W`, default 4: width of `state_out`; must be at least 4.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `ctl_op`  in  6: opcode field from the instruction register.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each: datapath controls.
- `alu_src_b`  out  2: 00 = B reg, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
- `alu_op`  out  2: 00 = add, 01 = subtract, 10 = funct field.
- `pc_src`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done`  out  1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op`  out  1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state_out`  out  STATE_W: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Every output defaults to 0. Each state asserts only the values listed below.
- FETCH:
  - Always asserts `mem_read`=1, `alu_src_b`=01.
  - Asserts `ir_write`=1 and `pc_write`=1 only when `mem_ready`=1.
  - Stays in FETCH while `mem_ready`=0; moves to DECODE when `mem_ready`=1.
- DECODE: `alu_src_b`=11. Next state by `ctl_op`:
  - 100011 (LW) or 101011 (SW) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (BEQ) → BRANCH.
  - 001000 → ADDIEX if `ENABLE_ADDI`=1.
  - 000010 → JUMP if `ENABLE_J`=1.
  - Any other opcode → FETCH, with `illegal_op`=1 in this cycle.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. LW → MEMRD; SW → MEMWR.
- MEMRD: `mem_read`=1, `i_or_d`=1. Stays until `mem_ready`=1, then → MEMWB.
- MEMWB: `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. → FETCH.
- MEMWR: `mem_write`=1, `i_or_d`=1. Stays until `mem_ready`=1; in that cycle `instr_done`=1, then → FETCH.
- EXECUTE: `alu_src_a`=1, `alu_op`=10. → ALUWB.
- ALUWB: `reg_dst`=1, `reg_write`=1, `instr_done`=1. → FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_src`=01, `pc_write_cond`=1, `instr_done`=1. → FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. → ADDIWB.
- ADDIWB: `reg_write`=1, `instr_done`=1. → FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1. → FETCH.

## Timing
- Reset: `rst_n` low forces the state to FETCH immediately, without waiting for a clock edge.
  - While reset is held, outputs show FETCH values with `mem_ready` gating applied. `pc_write` and `ir_write` are effectively ignored because the datapath is also in reset.
  - `instr_done`=0, `illegal_op`=0, `state_out`=0.
- Reset asserted mid-instruction abandons that instruction. No write-back or memory write occurs after `rst_n` falls.
- State register updates on the rising `clk` edge.
- Outputs are decoded from the current state, plus `mem_ready` in FETCH, MEMRD and MEMWR.
- `ctl_op` must be stable from DECODE to the end of the instruction. It is sampled in DECODE and MEMADR.
- Latency with zero wait states:
  - LW: 5 cycles.
  - SW, R-type and ADDI: 4 cycles.
  - BEQ and J: 3 cycles.
  - Illegal opcode: 2 cycles (FETCH, DECODE).
- Each `mem_ready`=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. No control outputs change during the stall.
- `mem_write` is held continuously until the cycle in which `mem_ready`=1. It must never pulse twice for one SW.

## Test plan
- Reset, then R-type (000000) with `mem_ready`=1: `state_out` sequence is 0,1,6,7,0. `reg_dst`=1 and `reg_write`=1 in state 7. `instr_done` pulses once.
- LW (100011) with `mem_ready`=0 for 2 cycles in MEMRD: 7 cycles total. `mem_read`=1 and `i_or_d`=1 for 3 consecutive cycles. `reg_write`=1 only in MEMWB.
- SW (101011) with `mem_ready` low for 1 cycle in FETCH: sequence is 0,0,1,2,5,0. `mem_write` is high for exactly 1 cycle.
- BEQ (000100), then J (000010): BEQ gives `pc_write_cond`=1 with `pc_src`=01 in state 8. J gives `pc_write`=1 with `pc_src`=10 in state 11.
- `ENABLE_J`=0 and `ctl_op`=000010: `illegal_op`=1 in DECODE, returns to FETCH, no `pc_write` outside FETCH.
- `rst_n` dropped while in MEMWR: `state_out`=0 with no clock edge, and `mem_write` deasserts immediately.
